pixel_feeder: RTL and testbench
===============================

// Module: pixel_feeder
// PURPOSE
//  Read-side counterpart of the line engine: fetches the frame buffer from DDR over the same
//  af (address FIFO) interface and unpacks read data (rdf) into a raster-ordered pixel stream
//  for the video output. Each af read command returns two 128-bit rdf words (8 pixels of 32b).
//  An internal credit-checked buffer absorbs rdf, which has no backpressure.
// PARAMETERS
//  H_ACTIVE    800  pixels per line; must be a multiple of 8, <= 1024
//  V_ACTIVE    600  lines per frame, <= 1024
//  BUF_DEPTH   32   internal rdf buffer depth in 128-bit words; power of 2, >= 4
// PORTS
//  clk            in   1    sole clock
//  rst            in   1    asynchronous, active-low reset
//  enable         in   1    level; 1 = stream frames continuously
//  frame_base     in   32   frame buffer base; only bits [27:22] are used
//  af_full        in   1    address FIFO full
//  af_addr_din    out  31   {6'b0, base[27:22], y[9:0], x[9:3], 2'b0}
//  af_cmd_din     out  3    3'b001 (read) whenever af_wr_en=1, else 3'b000
//  af_wr_en       out  1    push command; asserted only when af_full=0
//  rdf_dout       in   128  read data; pixel n (n=0..3, lowest x first) in [32n+23:32n]
//  rdf_valid      in   1    rdf_dout valid this cycle
//  video          out  24   pixel {R,G,B}
//  video_valid    out  1    video holds a pixel
//  video_ready    in   1    sink accepts pixel when video_valid & video_ready
//  video_sof      out  1    with video_valid: pixel is (0,0) of a frame
// BEHAVIOUR
//  Reset: af_wr_en=0, af_addr_din=0, af_cmd_din=0, video_valid=0, video=0, video_sof=0;
//   buffer empty, outstanding=0, request x/y=0, state IDLE.
//  FSM (request side): IDLE -> REQ when enable=1; latch frame_base[27:22] on this transition.
//   REQ: issue read for (rx,ry) if af_full=0 and credit ok, else STALL (af_wr_en=0).
//   STALL -> REQ when af_full=0 and credit ok. Registered: af_wr_en rises the cycle after
//   the decision; af_addr_din/af_cmd_din stable while af_wr_en=1.
//  Request stepping: rx += 8 per accepted command; at rx=H_ACTIVE-8 wrap rx=0, ry+=1; after
//   (H_ACTIVE-8, V_ACTIVE-1) wrap to (0,0): if enable=1 relatch frame_base, stay REQ; else IDLE.
//   enable deassert mid-frame: current frame completes, then IDLE.
//  Credit: issue only if 2*outstanding + fill + 2 <= BUF_DEPTH (outstanding = commands issued,
//   rdf words not yet received, counted per word). Simultaneous issue and rdf_valid: counters
//   updated with both deltas in the same cycle. rdf_valid with buffer full is a protocol
//   violation (cannot occur under credit); word is dropped, no state corruption.
//  Output side: pops a 128-bit word, emits 4 pixels in order n=0..3, one per handshake;
//   output pixel counters (vx,vy) track raster independently; video_sof=1 at (0,0).
//   video/video_sof held stable while video_valid & ~video_ready. First pixel of a frame
//   appears no earlier than 2 cycles after its rdf word. Empty buffer: video_valid=0 (underflow).
//  Arithmetic: fill, outstanding sized clog2(BUF_DEPTH)+1 bits; x,y 10 bits unsigned.
//  Reset mid-operation: all state cleared asynchronously; DDR controller shares reset, so no
//   pre-reset rdf words arrive after release.
// CONFIGURATION
//  PIXEL_FEEDER_STATS_EN defined: adds output underflow_cnt[15:0] (reset 0), +1 each cycle
//   video_valid=0 while in REQ/STALL after the first pixel of a frame was output, saturating
//   at 16'hFFFF; and output frame_cnt[15:0], +1 per completed output frame, wraps.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset, enable=1, base=32'h0040_0000, af_full=0, ideal rdf (2 words, 3 cycles after cmd):
//    first cmd addr {6'b0,6'h01,10'd0,7'd0,2'b0}; 100 cmds/line; 60000 cmds/frame.
//  2 Pixel order: rdf words 0x..03_02_01_00 pattern -> video sequence x=0,1,2,... with
//    video_sof only on first pixel; 480000 pixels then sof again.
//  3 Backpressure: video_ready=0 for 200 cycles -> af_wr_en stops with fill+2*out<=BUF_DEPTH,
//    no rdf word lost, video held stable; resume -> stream continues in order.
//  4 af_full=1 for 50 cycles mid-line -> af_wr_en=0 throughout; next cmd is next x, no skip/dup.
//  5 enable=0 at pixel (400,300) -> frame finishes to (799,599), FSM IDLE, no further cmds;
//    change frame_base mid-frame -> takes effect only at next frame's first command.
//  6 rst low mid-frame -> all outputs 0 immediately; after release, restart at (0,0).

Source files
------------

// File: rtl/pixel_feeder.sv
// pixel_feeder: fetches a raster frame buffer from DDR over the af/rdf interface and streams it
// as 24-bit pixels. Define PIXEL_FEEDER_STATS_EN to add underflow and frame counters.
module pixel_feeder #(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int BUF_DEPTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_enable,
    input  logic [31:0]  i_frame_base,
    input  logic         i_af_full,
    output logic [30:0]  o_af_addr_din,
    output logic [2:0]   o_af_cmd_din,
    output logic         o_af_wr_en,
    input  logic [127:0] i_rdf_dout,
    input  logic         i_rdf_valid,
    output logic [23:0]  o_video,
    output logic         o_video_valid,
    input  logic         i_video_ready,
    output logic         o_video_sof
`ifdef PIXEL_FEEDER_STATS_EN
    ,
    output logic [15:0]  o_underflow_cnt,
    output logic [15:0]  o_frame_cnt
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [9:0]    LP_X_LAST  = 10'(H_ACTIVE - 8);
    localparam logic [9:0]    LP_VX_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]    LP_Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [CW-1:0] LP_DEPTH   = CW'(BUF_DEPTH);
    localparam logic [CW+1:0] LP_LIMIT   = (CW+2)'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t        r_state;
    logic [9:0]    r_rx;
    logic [9:0]    r_ry;
    logic [5:0]    r_base;
    logic          r_af_wr_en;
    logic [30:0]   r_af_addr;
    logic [2:0]    r_af_cmd;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_fill;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [95:0]   r_mem [BUF_DEPTH];
    logic [95:0]   r_word;
    logic          r_word_vld;
    logic [1:0]    r_idx;
    logic [9:0]    r_vx;
    logic [9:0]    r_vy;
    logic [23:0]   r_video;
    logic          r_video_valid;
    logic          r_video_sof;

    logic [CW+1:0] w_need;
    logic          w_credit_ok;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_adv;
    logic          w_fifo_empty;
    logic          w_out_dec;
    logic [95:0]   w_rdf_pix;
    logic [23:0]   w_pix;
    logic          w_unused;

    // Only the pixel fields of each rdf word are stored; the alpha bytes are discarded.
    assign w_rdf_pix = {i_rdf_dout[119:96], i_rdf_dout[87:64], i_rdf_dout[55:32], i_rdf_dout[23:0]};
    assign w_unused  = ^{i_rdf_dout[127:120], i_rdf_dout[95:88], i_rdf_dout[63:56], i_rdf_dout[31:24],
                         i_frame_base[31:28], i_frame_base[21:0]};

    // Outstanding words are weighted twice so rdf can never overrun the buffer.
    assign w_need       = {1'b0, r_out, 1'b0} + {2'b00, r_fill} + (CW+2)'(2);
    assign w_credit_ok  = (w_need <= LP_LIMIT);
    assign w_issue      = (r_state != ST_IDLE) & ~i_af_full & w_credit_ok;
    assign w_push       = i_rdf_valid & (r_fill != LP_DEPTH);
    assign w_out_dec    = i_rdf_valid & (r_out != {CW{1'b0}});
    assign w_fifo_empty = (r_fill == {CW{1'b0}});
    assign w_adv        = ~r_video_valid | i_video_ready;
    assign w_pop        = ~w_fifo_empty & (~r_word_vld | (w_adv & (r_idx == 2'd3)));

    // Select the current pixel of the unpacked word.
    always_comb begin
        w_pix = 24'h000000;
        case (r_idx)
            2'd0:    w_pix = r_word[23:0];
            2'd1:    w_pix = r_word[47:24];
            2'd2:    w_pix = r_word[71:48];
            2'd3:    w_pix = r_word[95:72];
            default: w_pix = 24'h000000;
        endcase
    end

    // Request FSM: walks the frame in 8-pixel steps and issues registered af read commands.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_rx       <= 10'd0;
            r_ry       <= 10'd0;
            r_base     <= 6'd0;
            r_af_wr_en <= 1'b0;
            r_af_addr  <= 31'd0;
            r_af_cmd   <= 3'b000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_af_wr_en <= 1'b0;
                    r_af_cmd   <= 3'b000;
                    if (i_enable) begin
                        r_base  <= i_frame_base[27:22];
                        r_state <= ST_REQ;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ, ST_STALL: begin
                    if (w_issue) begin
                        r_af_wr_en <= 1'b1;
                        r_af_cmd   <= 3'b001;
                        r_af_addr  <= {6'b000000, r_base, r_ry, r_rx[9:3], 2'b00};
                        r_state    <= ST_REQ;
                        if (r_rx == LP_X_LAST) begin
                            r_rx <= 10'd0;
                            if (r_ry == LP_Y_LAST) begin
                                r_ry <= 10'd0;
                                // Frame boundary: the only point where base and enable are re-sampled.
                                if (i_enable) begin
                                    r_base <= i_frame_base[27:22];
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end else begin
                                r_ry <= r_ry + 10'd1;
                            end
                        end else begin
                            r_rx <= r_rx + 10'd8;
                        end
                    end else begin
                        r_af_wr_en <= 1'b0;
                        r_af_cmd   <= 3'b000;
                        r_state    <= ST_STALL;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_af_wr_en <= 1'b0;
                    r_af_cmd   <= 3'b000;
                end
            endcase
        end
    end

    // Buffer pointers, fill level and outstanding-word count, each updated with both deltas at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_fill   <= {CW{1'b0}};
            r_out    <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            r_fill <= r_fill + CW'(w_push) - CW'(w_pop);
            r_out  <= r_out + (w_issue ? CW'(2) : {CW{1'b0}}) - CW'(w_out_dec);
        end
    end

    // Buffer storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rdf_pix;
        end
    end

    // Output side: unpack buffered words into a registered valid/ready pixel stream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word        <= 96'd0;
            r_word_vld    <= 1'b0;
            r_idx         <= 2'd0;
            r_vx          <= 10'd0;
            r_vy          <= 10'd0;
            r_video       <= 24'h000000;
            r_video_valid <= 1'b0;
            r_video_sof   <= 1'b0;
        end else begin
            if (w_adv) begin
                if (r_word_vld) begin
                    r_video       <= w_pix;
                    r_video_valid <= 1'b1;
                    r_video_sof   <= (r_vx == 10'd0) && (r_vy == 10'd0);
                    if (r_vx == LP_VX_LAST) begin
                        r_vx <= 10'd0;
                        r_vy <= (r_vy == LP_Y_LAST) ? 10'd0 : r_vy + 10'd1;
                    end else begin
                        r_vx <= r_vx + 10'd1;
                    end
                end else begin
                    r_video_valid <= 1'b0;
                end
            end
            if (w_pop) begin
                r_word     <= r_mem[r_rd_ptr];
                r_word_vld <= 1'b1;
                r_idx      <= 2'd0;
            end else if (w_adv && r_word_vld) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_word_vld <= 1'b0;
                end
            end
        end
    end

`ifdef PIXEL_FEEDER_STATS_EN
    logic        r_video_eof;
    logic        r_frame_active;
    logic [15:0] r_underflow_cnt;
    logic [15:0] r_frame_cnt;

    // Statistics: underflow cycles inside a started frame (saturating) and completed frames.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_video_eof     <= 1'b0;
            r_frame_active  <= 1'b0;
            r_underflow_cnt <= 16'h0000;
            r_frame_cnt     <= 16'h0000;
        end else begin
            if (w_adv && r_word_vld) begin
                r_video_eof <= (r_vx == LP_VX_LAST) && (r_vy == LP_Y_LAST);
            end
            if (r_video_valid && i_video_ready && r_video_eof) begin
                r_frame_active <= 1'b0;
                r_frame_cnt    <= r_frame_cnt + 16'h0001;
            end else if (r_video_valid && i_video_ready && r_video_sof) begin
                r_frame_active <= 1'b1;
            end
            if (r_frame_active && !r_video_valid && (r_state != ST_IDLE) &&
                (r_underflow_cnt != 16'hFFFF)) begin
                r_underflow_cnt <= r_underflow_cnt + 16'h0001;
            end
        end
    end

    assign o_underflow_cnt = r_underflow_cnt;
    assign o_frame_cnt     = r_frame_cnt;
`endif

    assign o_af_wr_en    = r_af_wr_en;
    assign o_af_addr_din = r_af_addr;
    assign o_af_cmd_din  = r_af_cmd;
    assign o_video       = r_video;
    assign o_video_valid = r_video_valid;
    assign o_video_sof   = r_video_sof;

endmodule

// File: tb/tb_pixel_feeder.sv
// Bench for pixel_feeder on a reduced 16x3 frame: a DDR responder plus raster reference model
// checked on every negedge, with a few hand-computed literal pins.
module tb_pixel_feeder;

    localparam int H = 16;
    localparam int V = 3;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [31:0]  frame_base;
    logic         af_full;
    logic [30:0]  af_addr_din;
    logic [2:0]   af_cmd_din;
    logic         af_wr_en;
    logic [127:0] rdf_dout;
    logic         rdf_valid;
    logic [23:0]  video;
    logic         video_valid;
    logic         video_ready;
    logic         video_sof;

    pixel_feeder #(.H_ACTIVE(H), .V_ACTIVE(V), .BUF_DEPTH(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_frame_base(frame_base),
        .i_af_full(af_full), .o_af_addr_din(af_addr_din), .o_af_cmd_din(af_cmd_din),
        .o_af_wr_en(af_wr_en), .i_rdf_dout(rdf_dout), .i_rdf_valid(rdf_valid),
        .o_video(video), .o_video_valid(video_valid), .i_video_ready(video_ready),
        .o_video_sof(video_sof)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    int tmo_cnt = 0, tmo_seen = 0;
    logic chk_no_cmd = 1'b0, chk_idle = 1'b0;
    logic [5:0] exp_base [0:15];

    int cx = 0, cy = 0, cf = 0, c_in_frame = 0, cmd_total = 0, epoch = 0, epoch_cmds = 0;
    int vx = 0, vy = 0, vf = 0, pix_total = 0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_sof = 1'b0;
    logic [23:0] prev_video = 24'h0;
    int ddr_t[$];
    logic [127:0] ddr_d[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // DDR returns pixel {base6, y[7:0], x[9:0]} decoded from the command address.
    function automatic logic [127:0] mk_word(input logic [30:0] a, input int k);
        logic [127:0] w;
        logic [9:0] xx;
        w = 128'h0;
        for (int n = 0; n < 4; n++) begin
            xx = {a[8:2], 3'b000} + 10'(4 * k + n);
            w[32*n +: 32] = {8'hEE, a[24:19], a[16:9], xx};
        end
        return w;
    endfunction

    // Compare process: DDR responder, command model and raster pixel model.
    initial begin
        rdf_valid = 1'b0;
        rdf_dout  = 128'h0;
        forever begin
            logic [30:0] ea;
            logic [23:0] ep;
            @(negedge clk);
            cyc++;
            if (tmo_cnt != tmo_seen) begin
                chk("wait_timeout", 64'(tmo_cnt), 64'(tmo_seen));
                tmo_seen = tmo_cnt;
            end
            if (!rst_n) begin
                chk("reset_outputs", 64'({af_wr_en, af_cmd_din, af_addr_din, video_valid, video, video_sof}), 64'd0);
                if (cmd_total > 0) begin
                    epoch = 1;
                    epoch_cmds = 0;
                end
                cx = 0; cy = 0; cf = 0; c_in_frame = 0;
                vx = 0; vy = 0; vf = 0;
                prev_valid = 1'b0;
                ddr_t.delete();
                ddr_d.delete();
                rdf_valid = 1'b0;
            end else begin
                if (af_wr_en) begin
                    ea = {6'b000000, exp_base[cf], 10'(cy), 7'(cx / 8), 2'b00};
                    chk("af_cmd", 64'(af_cmd_din), 64'(3'b001));
                    chk("af_addr", 64'(af_addr_din), 64'(ea));
                    if (epoch == 0 && cmd_total == 0) chk("first_cmd_lit", 64'(af_addr_din), 64'(31'h0008_0000));
                    if (epoch == 0 && cmd_total == 1) chk("second_cmd_lit", 64'(af_addr_din), 64'(31'h0008_0004));
                    if (epoch == 0 && cmd_total == 2) chk("line1_cmd_lit", 64'(af_addr_din), 64'(31'h0008_0200));
                    if (epoch == 1 && epoch_cmds == 0) chk("post_reset_cmd_lit", 64'(af_addr_din), 64'(31'h0018_0000));
                    for (int k = 0; k < 2; k++) begin
                        ddr_t.push_back(cyc + 3);
                        ddr_d.push_back(mk_word(af_addr_din, k));
                    end
                    cmd_total++; epoch_cmds++; c_in_frame++;
                    cx += 8;
                    if (cx == H) begin
                        cx = 0; cy++;
                        if (cy == V) begin cy = 0; cf++; c_in_frame = 0; end
                    end
                end
                if (chk_no_cmd) chk("af_wr_en_quiet", 64'(af_wr_en), 64'd0);
                if (chk_idle) chk("video_idle", 64'(video_valid), 64'd0);
                if (prev_valid && !prev_ready)
                    chk("video_hold", 64'({video_valid, video_sof, video}), 64'({1'b1, prev_sof, prev_video}));
                if (video_valid && video_ready) begin
                    ep = {exp_base[vf], 8'(vy), 10'(vx)};
                    chk("video_pix", 64'(video), 64'(ep));
                    chk("video_sof", 64'(video_sof), 64'((vx == 0 && vy == 0) ? 1 : 0));
                    if (epoch == 0 && pix_total == 0) chk("pix0_lit", 64'({video_sof, video}), 64'({1'b1, 24'h040000}));
                    if (epoch == 0 && pix_total == 5) chk("pix5_lit", 64'(video), 64'(24'h040005));
                    if (epoch == 0 && pix_total == 16) chk("pix16_lit", 64'(video), 64'(24'h040400));
                    if (epoch == 0 && pix_total == 96) chk("frame2_lit", 64'({video_sof, video}), 64'({1'b1, 24'h080000}));
                    pix_total++;
                    vx++;
                    if (vx == H) begin
                        vx = 0; vy++;
                        if (vy == V) begin vy = 0; vf++; end
                    end
                end
                prev_valid = video_valid;
                prev_ready = video_ready;
                prev_sof   = video_sof;
                prev_video = video;
                if (ddr_t.size() > 0 && ddr_t[0] <= cyc) begin
                    rdf_valid = 1'b1;
                    rdf_dout  = ddr_d.pop_front();
                    void'(ddr_t.pop_front());
                end else begin
                    rdf_valid = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pix(input int target, input int budget);
        int n;
        n = 0;
        while (pix_total < target && n < budget) begin tick(); n++; end
        if (pix_total < target) tmo_cnt++;
    endtask

    task automatic wait_cmd(input int frame, input int idx, input int budget);
        int n;
        n = 0;
        while (!(cf == frame && c_in_frame >= idx) && n < budget) begin tick(); n++; end
        if (!(cf == frame && c_in_frame >= idx)) tmo_cnt++;
    endtask

    // Directed stimulus sequence.
    initial begin
        int pt0;
        rst_n = 1'b0; enable = 1'b0; frame_base = 32'h0; af_full = 1'b0; video_ready = 1'b1;
        for (int i = 0; i < 16; i++) exp_base[i] = (i < 2) ? 6'd1 : 6'd2;
        repeat (3) tick();
        rst_n = 1'b1;
        frame_base = 32'h0040_0000;
        enable = 1'b1;
        // New base mid-frame 1 applies from frame 2.
        wait_cmd(1, 3, 2000);
        frame_base = 32'h0080_0000;
        // Long sink stall inside frame 2.
        wait_pix(2 * H * V + 10, 3000);
        video_ready = 1'b0;
        repeat (100) tick();
        chk_no_cmd = 1'b1;
        repeat (100) tick();
        chk_no_cmd = 1'b0;
        video_ready = 1'b1;
        // af_full held mid-line in frame 3.
        wait_cmd(3, 1, 2000);
        af_full = 1'b1;
        tick();
        chk_no_cmd = 1'b1;
        repeat (49) tick();
        af_full = 1'b0;
        chk_no_cmd = 1'b0;
        // Disable mid-frame 4: frame completes, then silence.
        wait_cmd(4, 3, 2000);
        enable = 1'b0;
        wait_pix(5 * H * V, 3000);
        tick();
        chk_no_cmd = 1'b1;
        chk_idle = 1'b1;
        repeat (40) tick();
        chk_no_cmd = 1'b0;
        chk_idle = 1'b0;
        for (int i = 5; i < 16; i++) exp_base[i] = 6'd3;
        frame_base = 32'h00C0_0000;
        enable = 1'b1;
        // Reset in the middle of frame 5, then restart from (0,0).
        wait_pix(5 * H * V + 20, 3000);
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) exp_base[i] = 6'd3;
        repeat (3) tick();
        rst_n = 1'b1;
        pt0 = pix_total;
        wait_pix(pt0 + 2 * H * V + 14, 3000);
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
